instr_fetch_ctrl: RTL
=====================

# instr_fetch_ctrl

Instruction-fetch sequencer that drives the address of the combinational instruction ROM and delivers one registered instruction per cycle to decode. It owns the program counter and handles start, stall, branch redirect and halt, and counts issued instructions. It sits between the instruction ROM and the decode/execute stage of the CPU core.

## Interface
- ADDR_WIDTH, 12, ROM address / PC width
- INSTR_WIDTH, 9, instruction word width
- START_ADDR, 0, PC load value on start/restart
- CNT_WIDTH, 16, issued-instruction counter width
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin execution at START_ADDR (sampled in IDLE or HALTED)
- stall  in  1  hold PC and fetched instruction
- branch_taken  in  1  redirect: current instr_out is a taken branch
- branch_target  in  ADDR_WIDTH  redirect address
- halt  in  1  current instr_out is a halt instruction
- rom_addr  out  ADDR_WIDTH  address to ROM (= PC register)
- rom_data  in  INSTR_WIDTH  ROM read data, same cycle as rom_addr
- instr_out  out  INSTR_WIDTH  fetched instruction register
- instr_valid  out  1  instr_out holds a live instruction
- pc_out  out  ADDR_WIDTH  address of instr_out
- running  out  1  state == FETCH
- done  out  1  state == HALTED
- issue_count  out  CNT_WIDTH  instructions issued since start

## Operation
- States: IDLE, FETCH, HALTED. Reset -> IDLE.
- IDLE: instr_valid=0; start=1 -> FETCH, PC<=START_ADDR, issue_count<=0.
- FETCH, no stall/redirect: instr_out<=rom_data, pc_out<=PC, instr_valid<=1, PC<=PC+1.
- PC increment wraps modulo 2^ADDR_WIDTH (max -> 0), no flag.
- Issue = instr_valid & ~stall; issue_count increments per issue, saturates at all-ones.
- branch_taken and halt are qualified by instr_valid; ignored when instr_valid=0.
- Priority in FETCH: halt > branch_taken > stall > normal fetch.
- halt: -> HALTED, instr_valid<=0, PC held; halt instruction counts as issued if ~stall.
- branch_taken: PC<=branch_target, instr_valid<=0 (flush fall-through, one bubble); counts as issued; stall ignored that cycle.
- stall (no halt/branch): PC, instr_out, pc_out, instr_valid all hold.
- HALTED: outputs hold except instr_valid=0; start=1 -> FETCH with PC<=START_ADDR, issue_count<=0.
- start ignored in FETCH.
- rom_addr = PC register combinationally; no other logic on that path.

## Timing
- Reset values: state IDLE, PC=START_ADDR, rom_addr=START_ADDR, instr_out=0, pc_out=0, instr_valid=0, running=0, done=0, issue_count=0.
- rst_n low mid-run: immediate return to reset values, asynchronously; no partial state retained.
- Start latency: start sampled at edge E0 -> running=1 after E0; ROM[START_ADDR] on instr_out with instr_valid=1 after E1.
- Steady state: one instruction per cycle, throughput 1.
- Branch penalty: branch sampled at edge En -> instr_valid=0 after En; instr_out=ROM[target], pc_out=target after En+1.
- Halt: sampled at En -> done=1, running=0, instr_valid=0 after En.
- stall asserted for k cycles extends the current instruction by exactly k cycles.

## Test plan
- Reset then start, ROM[i]=i+0x100 (9-bit): instr_out sequence 0x100,0x101,0x102 at pc_out 0,1,2, one per cycle, first valid 2 edges after start; issue_count=3 after three issues.
- Branch at pc_out=5 to 0x020: one cycle instr_valid=0, next instr_out=ROM[0x020], pc_out=0x020, then 0x021; ROM[6] never valid.
- stall high 3 cycles while pc_out=4: instr_out/pc_out frozen 3 cycles, issue_count unchanged, then pc_out=5.
- halt at pc_out=7 together with branch_taken and stall=0: done=1, instr_valid=0, branch ignored, issue_count=8; start then restarts at START_ADDR with issue_count=0.
- Wrap: branch to 0xFFF: pc_out 0xFFF followed by pc_out 0x000, no bubble.
- rst_n pulsed low mid-run asynchronously (between edges): all outputs at reset values immediately; no fetch until next start.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational ROM
// address and registers one instruction per cycle toward decode. Handles
// start/restart, stall, taken-branch redirect (one bubble) and halt, and
// keeps a saturating count of issued instructions.
module instr_fetch_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int INSTR_WIDTH = 9,
    parameter int START_ADDR  = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   halt,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic                   running,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   issue_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_t                 state_r, state_s;
    logic [ADDR_WIDTH-1:0]  pc_r, pc_s;
    logic [INSTR_WIDTH-1:0] instr_r, instr_s;
    logic [ADDR_WIDTH-1:0]  pc_out_r, pc_out_s;
    logic                   valid_r, valid_s;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_s;
    logic [CNT_WIDTH-1:0]   cnt_inc_s;
    logic                   halt_q_s;
    logic                   branch_q_s;

    // halt/branch only mean something when instr_out holds a live instruction
    assign halt_q_s   = valid_r & halt;
    assign branch_q_s = valid_r & branch_taken;
    assign cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

    // ROM address is the PC register itself, no logic in between
    assign rom_addr    = pc_r;
    assign instr_out   = instr_r;
    assign instr_valid = valid_r;
    assign pc_out      = pc_out_r;
    assign issue_count = cnt_r;
    assign running     = (state_r == ST_FETCH);
    assign done        = (state_r == ST_HALTED);

    // Next-state and datapath update; priority halt > branch > stall > fetch
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        instr_s  = instr_r;
        pc_out_s = pc_out_r;
        valid_s  = valid_r;
        cnt_s    = cnt_r;
        case (state_r)
            ST_IDLE, ST_HALTED: begin
                valid_s = 1'b0;
                if (start) begin
                    state_s = ST_FETCH;
                    pc_s    = START_PC;
                    cnt_s   = {CNT_WIDTH{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                if (halt_q_s) begin
                    // halt retires only if decode is not stalled
                    state_s = ST_HALTED;
                    valid_s = 1'b0;
                    if (!stall) begin
                        cnt_s = cnt_inc_s;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else if (branch_q_s) begin
                    // flush the fall-through fetch; branch retires even under stall
                    pc_s    = branch_target;
                    valid_s = 1'b0;
                    cnt_s   = cnt_inc_s;
                end else if (stall) begin
                    valid_s = valid_r;
                end else begin
                    instr_s  = rom_data;
                    pc_out_s = pc_r;
                    valid_s  = 1'b1;
                    pc_s     = pc_r + PC_ONE;
                    if (valid_r) begin
                        cnt_s = cnt_inc_s;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            pc_r     <= START_PC;
            instr_r  <= {INSTR_WIDTH{1'b0}};
            pc_out_r <= {ADDR_WIDTH{1'b0}};
            valid_r  <= 1'b0;
            cnt_r    <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            instr_r  <= instr_s;
            pc_out_r <= pc_out_s;
            valid_r  <= valid_s;
            cnt_r    <= cnt_s;
        end
    end

endmodule
